// File: rtl/obi_demux_ot.sv
// -----------------------------------------------------------------------------
// obi_demux_ot
//
// Purpose:
//   Routes one OBI master to NSLAVE OBI targets by address rule. Up to MAX_OT
//   granted-but-unanswered transactions may be in flight. All of them must
//   target the same slave, which keeps responses in order without reorder
//   buffers. A request to a different slave waits until the outstanding
//   count drains to zero.
//
// Parameters:
//   NSLAVE       number of slave ports (>= 1)
//   NRULES       number of entries in addr_map_i
//   MAX_OT       maximum outstanding transactions (>= 1)
//   DEFAULT_IDX  slave used for unmapped addresses (< NSLAVE)
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous reset, active-low
//   addr_map_i     address rules {idx, start_addr, end_addr}, end exclusive
//   master_req_i   request from the single master
//   master_resp_o  gnt / rvalid / rdata back to the master
//   slave_req_o    per-slave requests (payload fanned out, req one-hot)
//   slave_resp_i   per-slave responses
//   ot_cnt_o       current outstanding transaction count
//   err_rvalid_o   sticky flag: unexpected rvalid seen (cleared by reset only)
//
// Configuration macro:
//   OBI_DEMUX_ERR_SLAVE_EN - when defined, unmapped addresses go to an
//   internal error target (index NSLAVE). That target grants immediately and
//   answers one cycle later with rdata 32'hBADACCE5. When the macro is not
//   defined, unmapped addresses go to slave DEFAULT_IDX.
// -----------------------------------------------------------------------------

package addr_map_rule_pkg;
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;
endpackage

package obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_demux_ot
    import obi_pkg::*;
#(
    parameter int unsigned NSLAVE      = 2,
    parameter int unsigned NRULES      = 1,
    parameter int unsigned MAX_OT      = 4,
    parameter int unsigned DEFAULT_IDX = 0
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  addr_map_rule_pkg::addr_map_rule_t [NRULES-1:0] addr_map_i,
    input  obi_req_t                                      master_req_i,
    output obi_resp_t                                     master_resp_o,
    output obi_req_t  [NSLAVE-1:0]                        slave_req_o,
    input  obi_resp_t [NSLAVE-1:0]                        slave_resp_i,
    output logic [$clog2(MAX_OT+1)-1:0]                   ot_cnt_o,
    output logic                                          err_rvalid_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OT + 1);
    // One extra index is reserved so the internal error target (index NSLAVE)
    // can be named; the default build never selects it.
    localparam int unsigned IDX_W = $clog2(NSLAVE + 1);

    localparam logic [CNT_W-1:0] MAX_OT_C   = CNT_W'(MAX_OT);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = '0;
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [IDX_W-1:0] NSLAVE_C   = IDX_W'(NSLAVE);

`ifdef OBI_DEMUX_ERR_SLAVE_EN
    localparam logic [IDX_W-1:0] UNMAPPED_C = NSLAVE_C;
    localparam logic [31:0]      ERR_RDATA_C = 32'hBADACCE5;
`else
    localparam logic [IDX_W-1:0] UNMAPPED_C = IDX_W'(DEFAULT_IDX);
`endif

    logic [CNT_W-1:0] otCnt_q, otCnt_d;
    logic [IDX_W-1:0] curIdx_q, curIdx_d;
    logic             errRvalid_q, errRvalid_d;

    logic [IDX_W-1:0] selIdx;
    logic             selGnt;
    logic             allow;
    logic             handshake;
    logic             curRvalid;
    logic [31:0]      curRdata;
    logic             takeRvalid;
    logic             strayRvalid;

`ifdef OBI_DEMUX_ERR_SLAVE_EN
    logic             errTgtRvalid_q;
`endif

    // Address decode. Rules are scanned from the highest index down so the
    // lowest matching rule is written last and wins. A rule whose idx does
    // not name a real slave is ignored rather than routed to a missing port.
    always_comb begin
        selIdx = UNMAPPED_C;
        for (int r = int'(NRULES) - 1; r >= 0; r--) begin
            if ((master_req_i.addr >= addr_map_i[r].start_addr) &&
                (master_req_i.addr <  addr_map_i[r].end_addr)   &&
                (addr_map_i[r].idx < NSLAVE)) begin
                selIdx = IDX_W'(addr_map_i[r].idx);
            end
        end
    end

    // Issue decision. Only registered state feeds 'allow', so an rvalid
    // arriving in the same cycle can never open the gate for a new grant.
    always_comb begin
        selGnt = 1'b0;
        for (int j = 0; j < int'(NSLAVE); j++) begin
            if (selIdx == IDX_W'(j)) begin
                selGnt = slave_resp_i[j].gnt;
            end
        end
`ifdef OBI_DEMUX_ERR_SLAVE_EN
        if (selIdx == NSLAVE_C) begin
            selGnt = 1'b1;
        end
`endif
        allow = master_req_i.req &
                ((otCnt_q == CNT_ZERO_C) |
                 ((selIdx == curIdx_q) & (otCnt_q < MAX_OT_C)));
        handshake = allow & selGnt;
    end

    // Request fan-out: every slave sees the payload, but only the selected
    // one sees req, and only while issue is allowed.
    always_comb begin
        for (int j = 0; j < int'(NSLAVE); j++) begin
            slave_req_o[j]     = master_req_i;
            slave_req_o[j].req = allow & (selIdx == IDX_W'(j));
        end
    end

    // Response mux from the slave that owns the outstanding transactions.
    // An rvalid with nothing outstanding is not forwarded.
    always_comb begin
        curRvalid = 1'b0;
        curRdata  = '0;
        for (int j = 0; j < int'(NSLAVE); j++) begin
            if (curIdx_q == IDX_W'(j)) begin
                curRvalid = slave_resp_i[j].rvalid;
                curRdata  = slave_resp_i[j].rdata;
            end
        end
`ifdef OBI_DEMUX_ERR_SLAVE_EN
        if (curIdx_q == NSLAVE_C) begin
            curRvalid = errTgtRvalid_q;
            curRdata  = ERR_RDATA_C;
        end
`endif
        takeRvalid           = curRvalid & (otCnt_q != CNT_ZERO_C);
        master_resp_o.gnt    = handshake;
        master_resp_o.rvalid = takeRvalid;
        master_resp_o.rdata  = takeRvalid ? curRdata : 32'h0;
    end

    // Protocol error detection: an rvalid from a slave that owns no
    // transactions, or any rvalid while nothing is outstanding.
    always_comb begin
        strayRvalid = 1'b0;
        for (int j = 0; j < int'(NSLAVE); j++) begin
            if (slave_resp_i[j].rvalid &&
                ((curIdx_q != IDX_W'(j)) || (otCnt_q == CNT_ZERO_C))) begin
                strayRvalid = 1'b1;
            end
        end
    end

    // Next-state: the counter moves only when exactly one of handshake and
    // accepted rvalid happens. The owning slave follows each handshake.
    always_comb begin
        otCnt_d     = otCnt_q;
        curIdx_d    = curIdx_q;
        errRvalid_d = errRvalid_q | strayRvalid;
        case ({handshake, takeRvalid})
            2'b10:   otCnt_d = otCnt_q + CNT_ONE_C;
            2'b01:   otCnt_d = otCnt_q - CNT_ONE_C;
            default: otCnt_d = otCnt_q;
        endcase
        if (handshake) begin
            curIdx_d = selIdx;
        end
    end

    // State registers. Reset discards any outstanding bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            otCnt_q     <= '0;
            curIdx_q    <= UNMAPPED_C;
            errRvalid_q <= 1'b0;
        end else begin
            otCnt_q     <= otCnt_d;
            curIdx_q    <= curIdx_d;
            errRvalid_q <= errRvalid_d;
        end
    end

    assign ot_cnt_o     = otCnt_q;
    assign err_rvalid_o = errRvalid_q;

`ifdef OBI_DEMUX_ERR_SLAVE_EN
    // Internal error target: it answers exactly one cycle after each grant
    // it receives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errTgtRvalid_q <= 1'b0;
        end else begin
            errTgtRvalid_q <= handshake & (selIdx == NSLAVE_C);
        end
    end

`ifndef SYNTHESIS
    // Report the address of every access routed to the error target.
    always @(posedge clk_i) begin
        if (rst_ni && handshake && (selIdx == NSLAVE_C)) begin
            $display("obi_demux_ot: unmapped access to 0x%08h", master_req_i.addr);
        end
    end
`endif
`endif

`ifndef SYNTHESIS
    // OBI requires the master to hold its request unchanged until granted.
    logic     reqPending_q;
    obi_req_t heldReq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reqPending_q <= 1'b0;
        end else begin
            reqPending_q <= master_req_i.req & ~master_resp_o.gnt;
        end
    end

    always_ff @(posedge clk_i) begin
        heldReq_q <= master_req_i;
    end

    always @(posedge clk_i) begin
        if (rst_ni && reqPending_q) begin
            assert (master_req_i == heldReq_q);
        end
    end
`endif

endmodule

// File: tb/tb_obi_demux_ot.sv
// -----------------------------------------------------------------------------
// tb_obi_demux_ot
//
// Directed bench for obi_demux_ot with NSLAVE=2, NRULES=2, MAX_OT=4 and
// DEFAULT_IDX=0. Rule 0 covers [0x0, 0x10000) and maps to slave 0. Rule 1
// covers [0x20000000, 0x30000000) and maps to slave 1. Both slaves always
// grant. Their rvalid and rdata are driven directly by each scenario task.
// Inputs change on the falling edge. Outputs are sampled 1 time unit later,
// well before the next rising edge.
// -----------------------------------------------------------------------------

module tb_obi_demux_ot;
    import obi_pkg::*;
    import addr_map_rule_pkg::*;

    localparam int unsigned NSLAVE      = 2;
    localparam int unsigned NRULES      = 2;
    localparam int unsigned MAX_OT      = 4;
    localparam int unsigned DEFAULT_IDX = 0;

    logic                           clk_i = 1'b0;
    logic                           rst_ni = 1'b0;
    addr_map_rule_t [NRULES-1:0]    addrMap;
    obi_req_t                       masterReq;
    obi_resp_t                      masterResp;
    obi_req_t  [NSLAVE-1:0]         slaveReq;
    obi_resp_t [NSLAVE-1:0]         slaveResp;
    logic [$clog2(MAX_OT+1)-1:0]    otCnt;
    logic                           errRvalid;

    int checkCount = 0;
    int failCount  = 0;

    obi_demux_ot #(
        .NSLAVE      (NSLAVE),
        .NRULES      (NRULES),
        .MAX_OT      (MAX_OT),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .addr_map_i    (addrMap),
        .master_req_i  (masterReq),
        .master_resp_o (masterResp),
        .slave_req_o   (slaveReq),
        .slave_resp_i  (slaveResp),
        .ot_cnt_o      (otCnt),
        .err_rvalid_o  (errRvalid)
    );

    always #5 clk_i = ~clk_i;

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Drive the master request; reads only, full byte enables.
    task automatic applyStimulus(input logic req, input logic [31:0] addr);
        masterReq.req   = req;
        masterReq.we    = 1'b0;
        masterReq.be    = 4'hF;
        masterReq.addr  = addr;
        masterReq.wdata = 32'h0;
    endtask

    // Drive one slave's response; grant stays high throughout.
    task automatic setSlaveResp(input int j, input logic rvalid, input logic [31:0] rdata);
        slaveResp[j].gnt    = 1'b1;
        slaveResp[j].rvalid = rvalid;
        slaveResp[j].rdata  = rdata;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        #1;
        checkCount++;
        if (otCnt !== 3'd0) begin
            failCount++; $display("[TB] FAIL reset_otcnt got=%0d exp=0", otCnt);
        end
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt, masterResp.rvalid, errRvalid} !== 5'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags got=%b exp=00000",
                     {slaveReq[1].req, slaveReq[0].req, masterResp.gnt, masterResp.rvalid, errRvalid});
        end
        checkCount++;
        if (masterResp.rdata !== 32'h0) begin
            failCount++; $display("[TB] FAIL reset_rdata got=%h exp=0", masterResp.rdata);
        end
        @(negedge clk_i) rst_ni = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk_i) applyStimulus(1'b1, 32'h100);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt} !== 3'b011) begin
            failCount++;
            $display("[TB] FAIL t1_route got=%b exp=011", {slaveReq[1].req, slaveReq[0].req, masterResp.gnt});
        end
        @(negedge clk_i) begin applyStimulus(1'b0, 32'h0); setSlaveResp(0, 1'b1, 32'h1234); end
        #1;
        checkCount++;
        if ({masterResp.rvalid, masterResp.rdata, otCnt} !== {1'b1, 32'h1234, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t1_resp got=%b/%h/%0d exp=1/00001234/1", masterResp.rvalid, masterResp.rdata, otCnt);
        end
        @(negedge clk_i) setSlaveResp(0, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({masterResp.rvalid, masterResp.rdata, otCnt} !== {1'b0, 32'h0, 3'd0}) begin
            failCount++;
            $display("[TB] FAIL t1_idle got=%b/%h/%0d exp=0/00000000/0", masterResp.rvalid, masterResp.rdata, otCnt);
        end
    endtask

    task automatic test_max_outstanding();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i) applyStimulus(1'b1, 32'h2000_0000 + 32'(k * 4));
            #1;
            checkCount++;
            if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt, otCnt} !== {3'b101, 3'(k)}) begin
                failCount++;
                $display("[TB] FAIL t2_grant%0d got=%b/%0d exp=101/%0d", k,
                         {slaveReq[1].req, slaveReq[0].req, masterResp.gnt}, otCnt, k);
            end
        end
        @(negedge clk_i) applyStimulus(1'b1, 32'h2000_0010);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt, otCnt} !== {3'b000, 3'd4}) begin
            failCount++;
            $display("[TB] FAIL t2_full got=%b/%0d exp=000/4",
                     {slaveReq[1].req, slaveReq[0].req, masterResp.gnt}, otCnt);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b1, 32'hA0);
        #1;
        checkCount++;
        if ({masterResp.gnt, masterResp.rvalid, otCnt} !== {2'b01, 3'd4}) begin
            failCount++;
            $display("[TB] FAIL t2_same_cycle got=%b/%b/%0d exp=0/1/4", masterResp.gnt, masterResp.rvalid, otCnt);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({masterResp.gnt, otCnt} !== {1'b1, 3'd3}) begin
            failCount++;
            $display("[TB] FAIL t2_fifth got=%b/%0d exp=1/3", masterResp.gnt, otCnt);
        end
        @(negedge clk_i) applyStimulus(1'b1, 32'h2000_0014);
        #1;
        checkCount++;
        if ({masterResp.gnt, otCnt} !== {1'b0, 3'd4}) begin
            failCount++;
            $display("[TB] FAIL t2_sixth_stall got=%b/%0d exp=0/4", masterResp.gnt, otCnt);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b1, 32'hA1);
        @(negedge clk_i) setSlaveResp(1, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({masterResp.gnt, otCnt} !== {1'b1, 3'd3}) begin
            failCount++;
            $display("[TB] FAIL t2_sixth got=%b/%0d exp=1/3", masterResp.gnt, otCnt);
        end
        @(negedge clk_i) begin applyStimulus(1'b0, 32'h0); setSlaveResp(1, 1'b1, 32'hA2); end
        repeat (4) @(negedge clk_i);
        setSlaveResp(1, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({otCnt, errRvalid} !== {3'd0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL t2_drain got=%0d/%b exp=0/0", otCnt, errRvalid);
        end
    endtask

    task automatic test_target_switch();
        @(negedge clk_i) applyStimulus(1'b1, 32'h200);
        @(negedge clk_i) applyStimulus(1'b1, 32'h204);
        #1;
        checkCount++;
        if ({slaveReq[0].req, masterResp.gnt, otCnt} !== {2'b11, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t3_second got=%b/%b/%0d exp=1/1/1", slaveReq[0].req, masterResp.gnt, otCnt);
        end
        @(negedge clk_i) applyStimulus(1'b1, 32'h2000_0000);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt, otCnt} !== {3'b000, 3'd2}) begin
            failCount++;
            $display("[TB] FAIL t3_stall got=%b/%0d exp=000/2",
                     {slaveReq[1].req, slaveReq[0].req, masterResp.gnt}, otCnt);
        end
        @(negedge clk_i) setSlaveResp(0, 1'b1, 32'h11);
        @(negedge clk_i);
        #1;
        checkCount++;
        if ({slaveReq[1].req, masterResp.gnt, masterResp.rvalid, otCnt} !== {3'b001, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t3_still_stall got=%b/%b/%b/%0d exp=0/0/1/1",
                     slaveReq[1].req, masterResp.gnt, masterResp.rvalid, otCnt);
        end
        @(negedge clk_i) setSlaveResp(0, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt, otCnt} !== {3'b101, 3'd0}) begin
            failCount++;
            $display("[TB] FAIL t3_switch got=%b/%0d exp=101/0",
                     {slaveReq[1].req, slaveReq[0].req, masterResp.gnt}, otCnt);
        end
        @(negedge clk_i) begin applyStimulus(1'b0, 32'h0); setSlaveResp(1, 1'b1, 32'hCAFE); end
        #1;
        checkCount++;
        if ({masterResp.rvalid, masterResp.rdata, otCnt} !== {1'b1, 32'hCAFE, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t3_slave1_resp got=%b/%h/%0d exp=1/0000cafe/1", masterResp.rvalid, masterResp.rdata, otCnt);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({otCnt, errRvalid} !== {3'd0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL t3_end got=%0d/%b exp=0/0", otCnt, errRvalid);
        end
    endtask

    task automatic test_same_cycle_and_err();
        @(negedge clk_i) applyStimulus(1'b1, 32'h300);
        @(negedge clk_i) begin applyStimulus(1'b1, 32'h304); setSlaveResp(0, 1'b1, 32'h22); end
        #1;
        checkCount++;
        if ({masterResp.gnt, masterResp.rvalid, otCnt} !== {2'b11, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t4_both got=%b/%b/%0d exp=1/1/1", masterResp.gnt, masterResp.rvalid, otCnt);
        end
        @(negedge clk_i) begin applyStimulus(1'b0, 32'h0); setSlaveResp(0, 1'b0, 32'h0); end
        #1;
        checkCount++;
        if (otCnt !== 3'd1) begin
            failCount++; $display("[TB] FAIL t4_unchanged got=%0d exp=1", otCnt);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b1, 32'hDEAD);
        #1;
        checkCount++;
        if ({masterResp.rvalid, errRvalid} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL t4_dropped got=%b/%b exp=0/0", masterResp.rvalid, errRvalid);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({errRvalid, otCnt} !== {1'b1, 3'd1}) begin
            failCount++; $display("[TB] FAIL t4_err_set got=%b/%0d exp=1/1", errRvalid, otCnt);
        end
        @(negedge clk_i) setSlaveResp(0, 1'b1, 32'h33);
        @(negedge clk_i) setSlaveResp(0, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({errRvalid, otCnt} !== {1'b1, 3'd0}) begin
            failCount++; $display("[TB] FAIL t4_err_sticky got=%b/%0d exp=1/0", errRvalid, otCnt);
        end
    endtask

    task automatic test_unmapped();
`ifdef OBI_DEMUX_ERR_SLAVE_EN
        @(negedge clk_i) applyStimulus(1'b1, 32'h4000_0000);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt, masterResp.rvalid} !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL t5_err_gnt got=%b exp=0010",
                     {slaveReq[1].req, slaveReq[0].req, masterResp.gnt, masterResp.rvalid});
        end
        @(negedge clk_i) applyStimulus(1'b0, 32'h0);
        #1;
        checkCount++;
        if ({masterResp.rvalid, masterResp.rdata, otCnt} !== {1'b1, 32'hBADACCE5, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t5_err_resp got=%b/%h/%0d exp=1/badacce5/1", masterResp.rvalid, masterResp.rdata, otCnt);
        end
        @(negedge clk_i);
        #1;
        checkCount++;
        if ({masterResp.rvalid, otCnt} !== {1'b0, 3'd0}) begin
            failCount++; $display("[TB] FAIL t5_err_done got=%b/%0d exp=0/0", masterResp.rvalid, otCnt);
        end
`else
        @(negedge clk_i) applyStimulus(1'b1, 32'h4000_0000);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt} !== 3'b011) begin
            failCount++;
            $display("[TB] FAIL t5_default got=%b exp=011", {slaveReq[1].req, slaveReq[0].req, masterResp.gnt});
        end
        @(negedge clk_i) begin applyStimulus(1'b0, 32'h0); setSlaveResp(0, 1'b1, 32'h55); end
        #1;
        checkCount++;
        if ({masterResp.rvalid, masterResp.rdata, otCnt} !== {1'b1, 32'h55, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t5_default_resp got=%b/%h/%0d exp=1/00000055/1", masterResp.rvalid, masterResp.rdata, otCnt);
        end
        @(negedge clk_i) setSlaveResp(0, 1'b0, 32'h0);
        #1;
        checkCount++;
        if (otCnt !== 3'd0) begin
            failCount++; $display("[TB] FAIL t5_default_done got=%0d exp=0", otCnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i) applyStimulus(1'b1, 32'h400 + 32'(k * 4));
        end
        @(negedge clk_i) applyStimulus(1'b0, 32'h0);
        #1;
        checkCount++;
        if (otCnt !== 3'd3) begin
            failCount++; $display("[TB] FAIL t6_pre got=%0d exp=3", otCnt);
        end
        @(negedge clk_i) rst_ni = 1'b0;
        #1;
        checkCount++;
        if ({otCnt, slaveReq[1].req, slaveReq[0].req, masterResp.gnt, errRvalid} !== {3'd0, 4'b0000}) begin
            failCount++;
            $display("[TB] FAIL t6_reset got=%0d/%b exp=0/0000", otCnt,
                     {slaveReq[1].req, slaveReq[0].req, masterResp.gnt, errRvalid});
        end
        @(negedge clk_i) rst_ni = 1'b1;
        @(negedge clk_i) applyStimulus(1'b1, 32'h2000_0100);
        #1;
        checkCount++;
        if ({slaveReq[1].req, slaveReq[0].req, masterResp.gnt} !== 3'b101) begin
            failCount++;
            $display("[TB] FAIL t6_no_stall got=%b exp=101", {slaveReq[1].req, slaveReq[0].req, masterResp.gnt});
        end
        @(negedge clk_i) begin applyStimulus(1'b0, 32'h0); setSlaveResp(1, 1'b1, 32'h77); end
        #1;
        checkCount++;
        if ({masterResp.rvalid, masterResp.rdata, otCnt} !== {1'b1, 32'h77, 3'd1}) begin
            failCount++;
            $display("[TB] FAIL t6_resp got=%b/%h/%0d exp=1/00000077/1", masterResp.rvalid, masterResp.rdata, otCnt);
        end
        @(negedge clk_i) setSlaveResp(1, 1'b0, 32'h0);
        #1;
        checkCount++;
        if ({otCnt, errRvalid} !== {3'd0, 1'b0}) begin
            failCount++; $display("[TB] FAIL t6_end got=%0d/%b exp=0/0", otCnt, errRvalid);
        end
    endtask

    initial begin
        addrMap[0] = '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0001_0000};
        addrMap[1] = '{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000};
        applyStimulus(1'b0, 32'h0);
        setSlaveResp(0, 1'b0, 32'h0);
        setSlaveResp(1, 1'b0, 32'h0);

        test_reset();
        test_single_read();
        test_max_outstanding();
        test_target_switch();
        test_same_cycle_and_err();
        test_unmapped();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
